// File: rtl/sdcard_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : sdcard_block_loader
// Description : Streams consecutive 512-byte SD blocks into RAM words.
//               Bytes are packed into WORD_BYTES-wide words and each word is
//               written through a request/acknowledge RAM port.
// Revision    : 1.0  initial release
// ============================================================================
module sdcard_block_loader #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 25,
    parameter int SDHC       = 1,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                    clk50,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             start_block,
    input  logic [ADDR_W-1:0]       word_count,
    input  logic [ADDR_W-1:0]       ram_base,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_address,
    output logic [8*WORD_BYTES-1:0] ram_data,
    input  logic                    ram_op_begun,
    output logic                    sd_rd,
    output logic                    sd_continue,
    output logic [31:0]             sd_addr,
    input  logic [7:0]              sd_data,
    input  logic                    sd_busy,
    input  logic                    sd_hndshk_o,
    output logic                    sd_hndshk_i,
    input  logic [15:0]             sd_error,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err,
    output logic [ADDR_W-1:0]       words_done
);

    // Byte index inside a word; a single-byte word still keeps a 1-bit index.
    localparam int c_IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    // Words per 512-byte block expressed as a shift amount.
    localparam int c_WPB_SHIFT = 9 - $clog2(WORD_BYTES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORD_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_INIT = 4'd1,
        S_READBLOCK = 4'd2,
        S_CAP       = 4'd3,
        S_ACK       = 4'd4,
        S_WRITE     = 4'd5,
        S_DRAIN     = 4'd6,
        S_DONE      = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    state_t                  r_state;
    logic [31:0]             r_start_block;
    logic [ADDR_W-1:0]       r_word_count;
    logic [ADDR_W-1:0]       r_ram_base;
    logic [ADDR_W-1:0]       r_words_done;
    logic [c_IDX_W-1:0]      r_byte_idx;
    logic [8*WORD_BYTES-1:0] r_data;
    logic                    r_continue;   // a block has already been started in this load
    logic                    r_drain_ack;  // handshake echo while discarding bytes
    logic                    r_done;
    logic [1:0]              r_err;

    logic [31:0]             w_blk;
    logic [c_IDX_W-1:0]      w_lane;
    logic [ADDR_W-1:0]       w_words_next;

    // Current block follows the word count: one block per 512/WORD_BYTES words.
    assign w_blk        = r_start_block + 32'(r_words_done >> c_WPB_SHIFT);
    assign w_lane       = (BIG_ENDIAN != 0) ? (c_LAST_IDX - r_byte_idx) : r_byte_idx;
    assign w_words_next = r_words_done + 1'b1;

    assign sd_addr      = (SDHC != 0) ? w_blk : (w_blk << 9);
    assign ram_address  = r_ram_base + r_words_done;
    assign ram_data     = r_data;
    assign words_done   = r_words_done;
    assign done         = r_done;
    assign err          = r_err;
    assign ram_we       = (r_state == S_WRITE);
    assign sd_rd        = (r_state == S_READBLOCK);
    assign sd_continue  = (r_state == S_READBLOCK) && r_continue;
    assign sd_hndshk_i  = (r_state == S_ACK) || ((r_state == S_DRAIN) && r_drain_ack);
    assign busy         = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

    // Load sequencer: block requests, byte capture/handshake, word writes.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_start_block <= '0;
            r_word_count  <= '0;
            r_ram_base    <= '0;
            r_words_done  <= '0;
            r_byte_idx    <= '0;
            r_data        <= '0;
            r_continue    <= 1'b0;
            r_drain_ack   <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_start_block <= start_block;
                        r_word_count  <= word_count;
                        r_ram_base    <= ram_base;
                        r_words_done  <= '0;
                        r_byte_idx    <= '0;
                        r_continue    <= 1'b0;
                        r_drain_ack   <= 1'b0;
                        r_done        <= 1'b0;
                        r_err         <= 2'b00;
                        r_state       <= S_WAIT_INIT;
                    end
                end
                S_WAIT_INIT: begin
                    if (!sd_busy) begin
                        if (sd_error != 16'h0000) begin
                            r_err   <= 2'b01;
                            r_state <= S_ERROR;
                        end else if (r_word_count == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_READBLOCK;
                        end
                    end
                end
                S_READBLOCK: begin
                    if (sd_busy) begin
                        r_continue <= 1'b1;
                        r_state    <= S_CAP;
                    end
                end
                S_CAP: begin
                    if (sd_hndshk_o) begin
                        r_data[{w_lane, 3'b000} +: 8] <= sd_data;
                        r_state <= S_ACK;
                    end else if (!sd_busy) begin
                        // Block ended: fine on a word boundary, fatal mid-word.
                        if (r_byte_idx == '0) begin
                            r_state <= S_READBLOCK;
                        end else begin
                            r_err   <= 2'b10;
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_ACK: begin
                    if (!sd_hndshk_o) begin
                        if (r_byte_idx == c_LAST_IDX) begin
                            r_byte_idx <= '0;
                            r_state    <= S_WRITE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_state    <= S_CAP;
                        end
                    end
                end
                S_WRITE: begin
                    if (ram_op_begun) begin
                        r_words_done <= w_words_next;
                        r_state      <= (w_words_next == r_word_count) ? S_DRAIN : S_CAP;
                    end
                end
                S_DRAIN: begin
                    r_drain_ack <= sd_hndshk_o;
                    if (!sd_busy && !sd_hndshk_o) begin
                        r_drain_ack <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdcard_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdcard_block_loader
// Description : Self-checking bench for sdcard_block_loader. Two instances
//               (16-bit big-endian SDHC, 64-bit little-endian byte-addressed)
//               share one SD controller model and one RAM acknowledge model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sdcard_block_loader;

    localparam int AW = 25;

    logic clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    int            sel;
    logic          rst_all, rst_cur, start;
    logic [31:0]   start_block;
    logic [AW-1:0] word_count, ram_base;
    logic          ram_op_begun, sd_busy, sd_hndshk_o;
    logic [7:0]    sd_data;
    logic [15:0]   sd_error;

    wire reset_a = rst_all | (rst_cur & (sel == 0));
    wire reset_b = rst_all | (rst_cur & (sel == 1));
    wire start_a = start & (sel == 0);
    wire start_b = start & (sel == 1);

    logic          ram_we_a, sd_rd_a, sd_continue_a, sd_hndshk_i_a, busy_a, done_a;
    logic [AW-1:0] ram_address_a, words_done_a;
    logic [15:0]   ram_data_a;
    logic [31:0]   sd_addr_a;
    logic [1:0]    err_a;
    logic          ram_we_b, sd_rd_b, sd_continue_b, sd_hndshk_i_b, busy_b, done_b;
    logic [AW-1:0] ram_address_b, words_done_b;
    logic [63:0]   ram_data_b;
    logic [31:0]   sd_addr_b;
    logic [1:0]    err_b;

    sdcard_block_loader #(.WORD_BYTES(2), .ADDR_W(AW), .SDHC(1), .BIG_ENDIAN(1)) u_dut_a (
        .clk50(clk50), .reset(reset_a), .start(start_a), .start_block(start_block),
        .word_count(word_count), .ram_base(ram_base), .ram_we(ram_we_a),
        .ram_address(ram_address_a), .ram_data(ram_data_a), .ram_op_begun(ram_op_begun),
        .sd_rd(sd_rd_a), .sd_continue(sd_continue_a), .sd_addr(sd_addr_a), .sd_data(sd_data),
        .sd_busy(sd_busy), .sd_hndshk_o(sd_hndshk_o), .sd_hndshk_i(sd_hndshk_i_a),
        .sd_error(sd_error), .busy(busy_a), .done(done_a), .err(err_a), .words_done(words_done_a)
    );

    sdcard_block_loader #(.WORD_BYTES(8), .ADDR_W(AW), .SDHC(0), .BIG_ENDIAN(0)) u_dut_b (
        .clk50(clk50), .reset(reset_b), .start(start_b), .start_block(start_block),
        .word_count(word_count), .ram_base(ram_base), .ram_we(ram_we_b),
        .ram_address(ram_address_b), .ram_data(ram_data_b), .ram_op_begun(ram_op_begun),
        .sd_rd(sd_rd_b), .sd_continue(sd_continue_b), .sd_addr(sd_addr_b), .sd_data(sd_data),
        .sd_busy(sd_busy), .sd_hndshk_o(sd_hndshk_o), .sd_hndshk_i(sd_hndshk_i_b),
        .sd_error(sd_error), .busy(busy_b), .done(done_b), .err(err_b), .words_done(words_done_b)
    );

    // View of whichever instance is currently under test.
    wire          cur_reset   = (sel == 0) ? reset_a : reset_b;
    wire          cur_ram_we  = (sel == 0) ? ram_we_a : ram_we_b;
    wire [AW-1:0] cur_ram_adr = (sel == 0) ? ram_address_a : ram_address_b;
    wire [63:0]   cur_ram_dat = (sel == 0) ? {48'h0, ram_data_a} : ram_data_b;
    wire          cur_sd_rd   = (sel == 0) ? sd_rd_a : sd_rd_b;
    wire          cur_sd_cont = (sel == 0) ? sd_continue_a : sd_continue_b;
    wire [31:0]   cur_sd_addr = (sel == 0) ? sd_addr_a : sd_addr_b;
    wire          cur_hs_i    = (sel == 0) ? sd_hndshk_i_a : sd_hndshk_i_b;
    wire          cur_busy    = (sel == 0) ? busy_a : busy_b;
    wire          cur_done    = (sel == 0) ? done_a : done_b;
    wire [1:0]    cur_err     = (sel == 0) ? err_a : err_b;
    wire [AW-1:0] cur_wdone   = (sel == 0) ? words_done_a : words_done_b;

    logic [7:0]    sd_mem [2048];   // four 512-byte block images, block n uses slot n%4
    logic [AW-1:0] wr_addr_q [$];
    logic [63:0]   wr_data_q [$];
    logic [31:0]   rd_addr_q [$];
    logic          rd_cont_q [$];
    int            sd_st, sd_cnt, sd_blk, short_limit, bytes_acked;
    int            ram_cnt, ram_delay, stab_err, we_run_max;
    logic [AW-1:0] hold_addr;
    logic [63:0]   hold_data;
    int            checks, passed, fails;

    // SD controller model: 4-phase byte handshake, 512 bytes per block request.
    always @(negedge clk50) begin
        if (cur_reset) begin
            sd_st = 0; sd_busy = 1'b0; sd_hndshk_o = 1'b0;
        end else begin
            case (sd_st)
                0: if (cur_sd_rd) begin
                    sd_blk = (sel == 0) ? int'(cur_sd_addr) : int'(cur_sd_addr >> 9);
                    rd_addr_q.push_back(cur_sd_addr);
                    rd_cont_q.push_back(cur_sd_cont);
                    sd_cnt = 0; sd_st = 1;
                end
                1: begin sd_busy = 1'b1; sd_st = 2; end
                2: if (sd_cnt == 512 || sd_cnt == short_limit) begin
                    sd_busy = 1'b0; sd_st = 0;
                end else begin
                    sd_data = sd_mem[(sd_blk % 4) * 512 + sd_cnt];
                    sd_hndshk_o = 1'b1; sd_st = 3;
                end
                3: if (cur_hs_i) begin sd_hndshk_o = 1'b0; sd_st = 4; end
                4: if (!cur_hs_i) begin sd_cnt++; bytes_acked++; sd_st = 2; end
                default: sd_st = 0;
            endcase
        end
    end

    // RAM model: acknowledges after ram_delay cycles and watches hold stability.
    always @(negedge clk50) begin
        if (cur_reset) begin
            ram_op_begun = 1'b0; ram_cnt = 0;
        end else if (ram_op_begun) begin
            ram_op_begun = 1'b0; ram_cnt = 0;
        end else if (cur_ram_we) begin
            if (ram_cnt == 0) begin
                hold_addr = cur_ram_adr; hold_data = cur_ram_dat;
            end else if (cur_ram_adr !== hold_addr || cur_ram_dat !== hold_data) begin
                stab_err++;
            end
            if (ram_cnt >= ram_delay) begin
                ram_op_begun = 1'b1;
                wr_addr_q.push_back(hold_addr);
                wr_data_q.push_back(hold_data);
                if (ram_cnt + 1 > we_run_max) we_run_max = ram_cnt + 1;
            end
            ram_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rd_cont_q.delete();
        bytes_acked = 0; stab_err = 0; we_run_max = 0;
    endtask

    task automatic do_start(input int blk, input int wc, input int base);
        start_block = 32'(blk); word_count = AW'(wc); ram_base = AW'(base);
        @(negedge clk50); start = 1'b1;
        @(negedge clk50); start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while ((!(cur_done || cur_err != 2'b00) || cur_busy) && n < 20000) begin
            @(negedge clk50); n++;
        end
        check({tag, " end reached"}, 64'(n < 20000), 64'(1));
    endtask

    task automatic wait_words(input string tag, input int w);
        int n = 0;
        while (int'(cur_wdone) < w && n < 20000) begin
            @(negedge clk50); n++;
        end
        check({tag, " progress"}, 64'(n < 20000), 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl"}, 64'({cur_ram_we, cur_sd_rd, cur_sd_cont, cur_hs_i, cur_busy, cur_done, cur_err}), 64'(0));
        check({tag, " addr"}, 64'({cur_ram_adr, cur_wdone}), 64'(0));
        check({tag, " data"}, cur_ram_dat, 64'(0));
        check({tag, " sd_addr"}, 64'(cur_sd_addr), 64'(0));
    endtask

    // Reference: word w holds SD stream bytes w*wb .. w*wb+wb-1 of the load.
    task automatic check_load(input string tag, input int blk0, input int nexp,
                              input int base, input int wb, input bit be);
        logic [63:0] exp_data;
        int off, lane;
        check({tag, " writes"}, 64'(wr_addr_q.size()), 64'(nexp));
        for (int w = 0; w < nexp && w < wr_addr_q.size(); w++) begin
            exp_data = '0;
            for (int j = 0; j < wb; j++) begin
                off  = w * wb + j;
                lane = be ? wb - 1 - j : j;
                exp_data[lane*8 +: 8] = sd_mem[((blk0 + off / 512) % 4) * 512 + off % 512];
            end
            check($sformatf("%s data[%0d]", tag, w), wr_data_q[w], exp_data);
            check($sformatf("%s addr[%0d]", tag, w), 64'(wr_addr_q[w]), 64'((base + w) % (1 << AW)));
        end
    endtask

    task automatic check_reads(input string tag, input int blk0, input int n, input bit hc);
        check({tag, " reads"}, 64'(rd_addr_q.size()), 64'(n));
        for (int k = 0; k < n && k < rd_addr_q.size(); k++) begin
            check($sformatf("%s sd_addr[%0d]", tag, k), 64'(rd_addr_q[k]),
                  hc ? 64'(blk0 + k) : 64'((blk0 + k) * 512));
            check($sformatf("%s cont[%0d]", tag, k), 64'(rd_cont_q[k]), 64'(k > 0));
        end
    endtask

    initial begin
        int blk, wc, base;
        checks = 0; passed = 0; fails = 0;
        sel = 0; rst_all = 1'b1; rst_cur = 1'b0; start = 1'b0;
        start_block = '0; word_count = '0; ram_base = '0; sd_error = 16'h0;
        ram_op_begun = 1'b0; sd_busy = 1'b0; sd_hndshk_o = 1'b0; sd_data = 8'h0;
        sd_st = 0; sd_cnt = 0; sd_blk = 0; short_limit = -1; ram_cnt = 0; ram_delay = 0;
        hold_addr = '0; hold_data = '0;
        clear_logs();
        for (int i = 0; i < 2048; i++) sd_mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) sd_mem[i] = 8'(8'h11 * (i + 1));

        // Reset state of both instances, then no spontaneous start.
        repeat (3) @(negedge clk50);
        check_all_zero("reset A");
        sel = 1; #1;
        check_all_zero("reset B");
        sel = 0;
        @(negedge clk50); rst_all = 1'b0;
        repeat (20) @(negedge clk50);
        check("no autostart", 64'({busy_a, sd_rd_a, busy_b, sd_rd_b}), 64'(0));

        // A1: four 16-bit big-endian words, remainder of block drained.
        clear_logs(); ram_delay = 0;
        do_start(0, 4, 'h10);
        wait_end("A1");
        check_load("A1", 0, 4, 'h10, 2, 1'b1);
        check("A1 word0", wr_data_q[0], 64'h1122);
        check("A1 bytes consumed", 64'(bytes_acked), 64'(512));
        check("A1 done/err", 64'({done_a, err_a}), 64'(3'b100));
        check("A1 words_done", 64'(words_done_a), 64'(4));
        check_reads("A1", 0, 1, 1'b1);

        // A2: random multi-block load with address wrap and an ignored start.
        clear_logs(); ram_delay = $urandom_range(0, 3);
        blk = $urandom_range(0, 1000); wc = $urandom_range(300, 600); base = (1 << AW) - 3;
        do_start(blk, wc, base);
        wait_words("A2", 20);
        check("A2 busy mid-load", 64'(busy_a), 64'(1));
        do_start(999, 1, 0);
        wait_end("A2");
        check_load("A2", blk, wc, base, 2, 1'b1);
        check_reads("A2", blk, (wc * 2 + 511) / 512, 1'b1);
        check("A2 words_done", 64'(words_done_a), 64'(wc));
        check("A2 done/err", 64'({done_a, err_a}), 64'(3'b100));
        check("A2 stability", 64'(stab_err), 64'(0));

        // A3: RAM acknowledge delayed 5 cycles.
        clear_logs(); ram_delay = 5;
        blk = $urandom_range(0, 1000); base = $urandom_range(0, 1000);
        do_start(blk, 3, base);
        wait_end("A3");
        check_load("A3", blk, 3, base, 2, 1'b1);
        check("A3 stability", 64'(stab_err), 64'(0));
        check("A3 we cycles", 64'(we_run_max), 64'(6));

        // A4: init error, then a healthy retry.
        clear_logs(); ram_delay = 0; sd_error = 16'h0004;
        do_start(0, 5, 0);
        wait_end("A4 err");
        check("A4 err code", 64'({done_a, err_a}), 64'(3'b001));
        check("A4 no writes", 64'(wr_addr_q.size()), 64'(0));
        check("A4 no reads", 64'(rd_addr_q.size()), 64'(0));
        sd_error = 16'h0000; clear_logs();
        blk = $urandom_range(0, 1000); base = $urandom_range(0, 5000);
        do_start(blk, 2, base);
        wait_end("A4 retry");
        check_load("A4 retry", blk, 2, base, 2, 1'b1);
        check("A4 retry done/err", 64'({done_a, err_a}), 64'(3'b100));

        // A5: asynchronous reset in the middle of a block.
        clear_logs();
        do_start(0, 100, 0);
        wait_words("A5", 10);
        rst_cur = 1'b1; #1;
        check_all_zero("A5 mid reset");
        @(negedge clk50); rst_cur = 1'b0;
        repeat (20) @(negedge clk50);
        check("A5 stays idle", 64'({busy_a, sd_rd_a, words_done_a}), 64'(0));

        // B1: 64-bit little-endian words, byte addressing, two blocks.
        sel = 1; clear_logs(); ram_delay = $urandom_range(0, 2);
        base = $urandom_range(0, 5000);
        do_start(3, 128, base);
        wait_end("B1");
        check_load("B1", 3, 128, base, 8, 1'b0);
        check_reads("B1", 3, 2, 1'b0);
        check("B1 first sd_addr", 64'(rd_addr_q[0]), 64'h600);
        check("B1 bytes consumed", 64'(bytes_acked), 64'(1024));
        check("B1 done/err", 64'({done_b, err_b}), 64'(3'b100));

        // B2: block ends two bytes into a word.
        clear_logs(); ram_delay = 0; short_limit = 18;
        do_start(0, 10, 0);
        wait_end("B2");
        check("B2 err code", 64'({done_b, err_b}), 64'(3'b010));
        check_load("B2", 0, 2, 0, 8, 1'b0);
        check("B2 words_done", 64'(words_done_b), 64'(2));
        short_limit = -1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdcard_block_loader.md
SDCARD_BLOCK_LOADER -- requirements
Module: sdcard_block_loader

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 2, bytes per RAM word; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter ADDR_W, default 25, RAM word address width.
REQ-003 SHALL have parameter SDHC, default 1; 1 means the SD address is a block address, 0 means it is a byte address.
REQ-004 SHALL have parameter BIG_ENDIAN, default 1; 1 means the first SD byte lands in the most significant byte of the word.
REQ-005 SHALL have the following ports:
- clk50  in  1  single clock; one clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a load.
- start_block  in  32  first SD block of the load, sampled at start.
- word_count  in  ADDR_W  number of words to load, sampled at start.
- ram_base  in  ADDR_W  first RAM word address, sampled at start.
- ram_we  out  1  write request.
- ram_address  out  ADDR_W  RAM word address.
- ram_data  out  8*WORD_BYTES  RAM word data.
- ram_op_begun  in  1  RAM acknowledge.
- sd_rd  out  1  block read request to the SD controller.
- sd_continue  out  1  multi-block continue.
- sd_addr  out  32  SD address.
- sd_data  in  8  SD byte.
- sd_busy  in  1  controller busy.
- sd_hndshk_o  in  1  byte ready.
- sd_hndshk_i  out  1  byte acknowledge.
- sd_error  in  16  controller error code.
- busy  out  1  load in progress.
- done  out  1  sticky completion flag.
- err  out  2  sticky error code: 00 none, 01 init, 10 short block.
- words_done  out  ADDR_W  words written in the current or last load.

Function
REQ-006 SHALL use the states IDLE, WAIT_INIT, READBLOCK, CAP, ACK, WRITE, DRAIN, DONE and ERROR.
REQ-007 In IDLE, DONE and ERROR, a start pulse SHALL latch start_block, word_count and ram_base, clear done, err and words_done, and go to WAIT_INIT.
REQ-008 A start pulse received in any other state SHALL be ignored.
REQ-009 In WAIT_INIT, when sd_busy=0 and sd_error=0, the block SHALL go to READBLOCK (or to DONE if word_count=0); when sd_busy=0 and sd_error!=0, it SHALL go to ERROR with err=01.
REQ-010 The current block address blk SHALL equal start_block + (words_done >> log2(512/WORD_BYTES)).
REQ-011 sd_addr SHALL equal blk when SDHC=1, and blk<<9 truncated to 32 bits when SDHC=0.
REQ-012 In READBLOCK, the block SHALL assert sd_rd, and SHALL also assert sd_continue if this is not the first block of the load; it SHALL go to CAP when sd_busy=1.
REQ-013 In CAP, when sd_hndshk_o=1, the block SHALL store sd_data into byte lane k and go to ACK.
REQ-014 Byte lane k SHALL be WORD_BYTES-1-byte_idx when BIG_ENDIAN=1, and byte_idx otherwise.
REQ-015 In CAP, if sd_busy=0 with byte_idx=0, the block SHALL go to READBLOCK.
REQ-016 In CAP, if sd_busy=0 with byte_idx!=0, the block SHALL go to ERROR with err=10.
REQ-017 In ACK, the block SHALL assert sd_hndshk_i until sd_hndshk_o=0, then increment byte_idx; on wrap to 0 it SHALL go to WRITE, otherwise back to CAP.
REQ-018 In WRITE, ram_we=1, ram_address=ram_base+words_done (mod 2^ADDR_W) and ram_data SHALL hold stable until ram_op_begun=1.
REQ-019 On ram_op_begun=1 in WRITE, the block SHALL increment words_done; if words_done then equals word_count it SHALL go to DRAIN, otherwise to CAP.
REQ-020 In DRAIN, the block SHALL acknowledge and discard the remaining bytes of the current block, and go to DONE when sd_busy=0.
REQ-021 busy SHALL equal 1 in every state except IDLE, DONE and ERROR.
REQ-022 done SHALL equal 1 in DONE; err SHALL hold its value until the next start.
REQ-023 ram_we, sd_rd, sd_continue and sd_hndshk_i SHALL be 0 in every state not listed above as driving them.
REQ-024 byte_idx SHALL be log2(WORD_BYTES) bits wide, or 1 bit wide when WORD_BYTES=1; words_done SHALL be ADDR_W bits wide.

Reset
REQ-025 Asserting reset at any time, including mid-block, SHALL force state=IDLE, all outputs to 0, and the latched registers and data word to 0.
REQ-026 After reset is released, the block SHALL wait for a start pulse and SHALL NOT start a load automatically.

Verification
REQ-027 Bench scenario: WORD_BYTES=2, BIG_ENDIAN=1, start_block=0, word_count=4, ram_base=0x10, bytes 11 22 33 44 55 66 77 88 -> writes 0x1122@0x10, 0x3344@0x11, 0x5566@0x12, 0x7788@0x13; DRAIN consumes 504 bytes; done=1; words_done=4.
REQ-028 Bench scenario: WORD_BYTES=8, BIG_ENDIAN=0, word_count=128 (two blocks) -> the second READBLOCK has sd_continue=1 and sd_addr=start_block+1; first word = bytes 0..7 little-endian.
REQ-029 Bench scenario: SDHC=0, start_block=3 -> sd_addr=0x600.
REQ-030 Bench scenario: sd_error=0x0004 with sd_busy=0 during WAIT_INIT -> ERROR, err=01, no ram_we; a subsequent start pulse with healthy SD -> load proceeds.
REQ-031 Bench scenario: WORD_BYTES=4 with sd_busy dropping after 2 bytes of a word -> err=10, the partial word is never written.
REQ-032 Bench scenario: ram_op_begun delayed 5 cycles -> ram_we, ram_address and ram_data stable for all 5 cycles; start pulse mid-load ignored; reset asserted mid-block -> immediate IDLE with all outputs 0.
